conv_window_feeder: RTL and testbench



---
 rtl/feeder_pkg.sv | 28 ++
 rtl/feeder_buffer.sv | 26 ++
 rtl/conv_window_feeder.sv | 277 +++++++++++++++++++++++++++
 tb/tb_conv_window_feeder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared types and constants for the convolution window feeder: FSM states,
// loop-control word layout and the control-word packing helper.
package feeder_pkg;

  localparam int DEFAULT_B_WIDTH = 8;
  localparam int CTRL_WIDTH      = 8;

  localparam int LC_VALID = 0;
  localparam int LC_FIRST = 1;
  localparam int LC_LAST  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [CTRL_WIDTH-1:0] pack_ctrl(input logic first_slot, input logic last_slot);
    logic [CTRL_WIDTH-1:0] w;
    w           = '0;
    w[LC_VALID] = 1'b1;
    w[LC_FIRST] = first_slot;
    w[LC_LAST]  = last_slot;
    return w;
  endfunction

endpackage

// File: rtl/feeder_buffer.sv
// Simple dual-port RAM holding the input feature map; one write port and one
// synchronous read port (data valid the cycle after the address).
module feeder_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [0:DEPTH-1];

  // Storage write and registered read; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    rd_data <= mem_r[raddr];
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Buffers one feature map and replays it in im2col order with zero padding.
// Optional macro FEEDER_OUT_REG_EN adds an output register stage (latency 2).
module conv_window_feeder
  import feeder_pkg::*;
#(
  parameter int M            = 2,
  parameter int N            = 1,
  parameter int B_WIDTH      = DEFAULT_B_WIDTH,
  parameter int STREAM_WIDTH = 2,
  parameter int ADDR_WIDTH   = 16,
  parameter int BATCH        = 1,
  parameter int DEPTH        = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_write,
  input  logic                            start,
  input  logic [STREAM_WIDTH*B_WIDTH-1:0] data_in,
  output logic [B_WIDTH-1:0]              data_out [0:M-1],
  output logic [ADDR_WIDTH-1:0]           counter,
  output logic [1:0]                      state,
  output logic                            wr_check,
  output logic [7:0]                      last,
  output logic                            ram_full,
  output logic [ADDR_WIDTH-1:0]           rd_idx,
  input  logic [1:0]                      stride,
  input  logic [ADDR_WIDTH-1:0]           chans_per_mem,
  input  logic [ADDR_WIDTH-1:0]           In_cols,
  output logic                            last_out,
  input  logic [ADDR_WIDTH-1:0]           k_dimension,
  input  logic [ADDR_WIDTH-1:0]           o_dimension,
  output logic [CTRL_WIDTH-1:0]           loop_ctrl
);

  localparam int WORD_W      = STREAM_WIDTH * B_WIDTH;
  localparam int RAM_AW      = $clog2(DEPTH);
  localparam int LANE_W      = ((M > STREAM_WIDTH) ? M : STREAM_WIDTH) * B_WIDTH;
  localparam int unused_cols = N;

  state_t                  state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0]   counter_r, i_r, c_r, k_r, o_r;
  logic [ADDR_WIDTH-1:0]   b_r, oy_r, ox_r, ky_r, kx_r, ch_r;
  logic [31:0]             tw_r, tr_r, pad_r;
  logic [1:0]              s_r, s_eff_s;
  logic                    ram_full_r, wr_check_r;
  logic                    we_s, issue_s, slot_pad_s, slot_first_s, slot_last_s;
  logic [31:0]             tw_calc_s, tr_calc_s, pad_num_s, pad_calc_s;
  logic [31:0]             iy_s, ix_s, cy_s, cx_s, addr_s;
  logic [WORD_W-1:0]       rd_data_s;
  logic [LANE_W-1:0]       lanes_s;
  logic                    v1_r, first1_r, last1_r, pad1_r;
  logic [ADDR_WIDTH-1:0]   rd_idx_r;
  logic [7:0]              pix_r;
  logic [B_WIDTH-1:0]      lane_r [0:M-1];
  logic [CTRL_WIDTH-1:0]   ctrl_r;
  logic                    done_r;
  logic                    unused_s;

  assign unused_s = ^addr_s[31:ADDR_WIDTH];

  feeder_buffer #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH),
    .AW    (RAM_AW)
  ) u_buffer (
    .clk     (clk),
    .we      (we_s),
    .waddr   (counter_r[RAM_AW-1:0]),
    .wdata   (data_in),
    .raddr   (addr_s[RAM_AW-1:0]),
    .rd_data (rd_data_s)
  );

  // Transfer sizes and padding derived from the live config ports, latched on start.
  always_comb begin
    s_eff_s   = (stride == 2'd0) ? 2'd1 : stride;
    tw_calc_s = 32'(In_cols) * 32'(In_cols) * 32'(chans_per_mem) * 32'(BATCH);
    tr_calc_s = 32'(k_dimension) * 32'(k_dimension) * 32'(chans_per_mem)
              * 32'(o_dimension) * 32'(o_dimension) * 32'(BATCH);
    pad_num_s = (32'(o_dimension) - 32'd1) * 32'(s_eff_s) + 32'(k_dimension) - 32'(In_cols);
    if (pad_num_s[31]) begin
      pad_calc_s = 32'd0;
    end else begin
      pad_calc_s = {1'b0, pad_num_s[31:1]};
    end
  end

  // Current slot's input coordinate, padding detection and clamped address.
  always_comb begin
    iy_s       = 32'(oy_r) * 32'(s_r) + 32'(ky_r) - pad_r;
    ix_s       = 32'(ox_r) * 32'(s_r) + 32'(kx_r) - pad_r;
    slot_pad_s = 1'b0;
    if (iy_s[31]) begin
      cy_s       = 32'd0;
      slot_pad_s = 1'b1;
    end else if (iy_s >= 32'(i_r)) begin
      cy_s       = 32'(i_r) - 32'd1;
      slot_pad_s = 1'b1;
    end else begin
      cy_s = iy_s;
    end
    if (ix_s[31]) begin
      cx_s       = 32'd0;
      slot_pad_s = 1'b1;
    end else if (ix_s >= 32'(i_r)) begin
      cx_s       = 32'(i_r) - 32'd1;
      slot_pad_s = 1'b1;
    end else begin
      cx_s = ix_s;
    end
    addr_s       = ((32'(b_r) * 32'(i_r) + cy_s) * 32'(i_r) + cx_s) * 32'(c_r) + 32'(ch_r);
    slot_first_s = (ky_r == '0) && (kx_r == '0) && (ch_r == '0);
    slot_last_s  = (ky_r == k_r - 1'b1) && (kx_r == k_r - 1'b1) && (ch_r == c_r - 1'b1);
    issue_s      = (state_r == READ) && (32'(counter_r) < tr_r);
    we_s         = (state_r == WRITE) && valid_write && !ram_full_r && (32'(counter_r) < tw_r);
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (start) state_nxt_s = WRITE; else state_nxt_s = IDLE;
      WRITE:   if (32'(counter_r) == tw_r) state_nxt_s = READ; else state_nxt_s = WRITE;
      READ:    if (!issue_s && !v1_r) state_nxt_s = DONE; else state_nxt_s = READ;
      DONE:    state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register, config latch, beat counter and im2col loop nest (c innermost).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      counter_r  <= '0;
      {i_r, c_r, k_r, o_r} <= '0;
      {b_r, oy_r, ox_r, ky_r, kx_r, ch_r} <= '0;
      tw_r       <= 32'd0;
      tr_r       <= 32'd0;
      pad_r      <= 32'd0;
      s_r        <= 2'd1;
      ram_full_r <= 1'b0;
      wr_check_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wr_check_r <= we_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            i_r   <= In_cols;
            c_r   <= chans_per_mem;
            k_r   <= k_dimension;
            o_r   <= o_dimension;
            s_r   <= s_eff_s;
            tw_r  <= tw_calc_s;
            tr_r  <= tr_calc_s;
            pad_r <= pad_calc_s;
            counter_r <= '0;
            {b_r, oy_r, ox_r, ky_r, kx_r, ch_r} <= '0;
          end
        end
        WRITE: begin
          if (we_s) begin
            counter_r <= counter_r + 1'b1;
          end else if (32'(counter_r) == tw_r) begin
            ram_full_r <= 1'b1;
            counter_r  <= '0;
          end
        end
        READ: begin
          if (issue_s) begin
            counter_r <= counter_r + 1'b1;
            if (ch_r != c_r - 1'b1) begin
              ch_r <= ch_r + 1'b1;
            end else begin
              ch_r <= '0;
              if (kx_r != k_r - 1'b1) begin
                kx_r <= kx_r + 1'b1;
              end else begin
                kx_r <= '0;
                if (ky_r != k_r - 1'b1) begin
                  ky_r <= ky_r + 1'b1;
                end else begin
                  ky_r <= '0;
                  if (ox_r != o_r - 1'b1) begin
                    ox_r <= ox_r + 1'b1;
                  end else begin
                    ox_r <= '0;
                    if (oy_r != o_r - 1'b1) begin
                      oy_r <= oy_r + 1'b1;
                    end else begin
                      oy_r <= '0;
                      b_r  <= b_r + 1'b1;
                    end
                  end
                end
              end
            end
          end
        end
        default: counter_r <= counter_r;
      endcase
    end
  end

  // Issue stage: tags travel alongside the RAM read so they line up with its data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r     <= 1'b0;
      first1_r <= 1'b0;
      last1_r  <= 1'b0;
      pad1_r   <= 1'b0;
      rd_idx_r <= '0;
      pix_r    <= 8'd0;
    end else begin
      v1_r <= issue_s;
      if (issue_s) begin
        first1_r <= slot_first_s;
        last1_r  <= slot_last_s;
        pad1_r   <= slot_pad_s;
        rd_idx_r <= addr_s[ADDR_WIDTH-1:0];
        pix_r    <= 8'(oy_r * o_r + ox_r);
      end
    end
  end

  assign lanes_s = LANE_W'(rd_data_s);

  // Output stage: padded slots and idle cycles drive zero lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < M; i++) lane_r[i] <= '0;
      ctrl_r <= '0;
      done_r <= 1'b0;
    end else begin
      for (int i = 0; i < M; i++) begin
        lane_r[i] <= (v1_r && !pad1_r) ? lanes_s[i*B_WIDTH +: B_WIDTH] : '0;
      end
      ctrl_r <= v1_r ? pack_ctrl(first1_r, last1_r) : '0;
      done_r <= (state_nxt_s == DONE);
    end
  end

`ifdef FEEDER_OUT_REG_EN
  logic [B_WIDTH-1:0]    lane_q_r [0:M-1];
  logic [CTRL_WIDTH-1:0] ctrl_q_r;
  logic                  done_q_r;

  // Extra retiming stage on the array-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < M; i++) lane_q_r[i] <= '0;
      ctrl_q_r <= '0;
      done_q_r <= 1'b0;
    end else begin
      for (int i = 0; i < M; i++) lane_q_r[i] <= lane_r[i];
      ctrl_q_r <= ctrl_r;
      done_q_r <= done_r;
    end
  end

  assign data_out  = lane_q_r;
  assign loop_ctrl = ctrl_q_r;
  assign last_out  = done_q_r;
`else
  assign data_out  = lane_r;
  assign loop_ctrl = ctrl_r;
  assign last_out  = done_r;
`endif

  assign counter  = counter_r;
  assign state    = state_r;
  assign wr_check = wr_check_r;
  assign last     = pix_r;
  assign ram_full = ram_full_r;
  assign rd_idx   = rd_idx_r;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench for conv_window_feeder: loads maps, replays them and checks
// every slot against an im2col reference built from nested loops.
module tb_conv_window_feeder;

  localparam int M  = 2;
  localparam int SW = 2;
  localparam int BW = 8;
  localparam int AW = 16;
`ifdef FEEDER_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst, valid_write, start;
  logic [SW*BW-1:0] data_in;
  logic [BW-1:0] data_out [0:M-1];
  logic [AW-1:0] counter, rd_idx, chans_per_mem, In_cols, k_dimension, o_dimension;
  logic [1:0]    state, stride;
  logic          wr_check, ram_full, last_out;
  logic [7:0]    last, loop_ctrl;

  int checks = 0;
  int errors = 0;
  logic [15:0] ref_mem [0:4095];
  int cfg_i, cfg_k, cfg_o, cfg_s, cfg_c;

  always #5 clk = ~clk;

  conv_window_feeder #(
    .M(M), .N(1), .B_WIDTH(BW), .STREAM_WIDTH(SW), .ADDR_WIDTH(AW), .BATCH(1), .DEPTH(4096)
  ) dut (
    .clk(clk), .rst(rst), .valid_write(valid_write), .start(start), .data_in(data_in),
    .data_out(data_out), .counter(counter), .state(state), .wr_check(wr_check),
    .last(last), .ram_full(ram_full), .rd_idx(rd_idx), .stride(stride),
    .chans_per_mem(chans_per_mem), .In_cols(In_cols), .last_out(last_out),
    .k_dimension(k_dimension), .o_dimension(o_dimension), .loop_ctrl(loop_ctrl)
  );

  task automatic set_cfg(input int i, input int k, input int o, input int s, input int c);
    cfg_i = i; cfg_k = k; cfg_o = o; cfg_s = s; cfg_c = c;
    In_cols = AW'(i); k_dimension = AW'(k); o_dimension = AW'(o);
    stride = 2'(s); chans_per_mem = AW'(c);
  endtask

  task automatic fill_mem(input bit rnd);
    for (int n = 0; n < cfg_i * cfg_i * cfg_c; n++) begin
      if (rnd) ref_mem[n] = 16'($urandom);
      else     ref_mem[n] = {8'(2 * n + 1), 8'(2 * n)};
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; valid_write = 1'b0; start = 1'b0; data_in = '0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_cfg(3, 3, 3, 1, 2);
    do_reset(20);
    rst = 1'b1;
    checks++;
    if (state !== 2'd0 || counter !== '0 || rd_idx !== '0 || last !== 8'd0) begin
      errors++;
      $display("FAIL reset_regs state=%0d counter=%0d rd_idx=%0d last=%0d required all 0",
               state, counter, rd_idx, last);
    end
    checks++;
    if (wr_check !== 1'b0 || ram_full !== 1'b0 || last_out !== 1'b0 || loop_ctrl !== 8'd0
        || data_out[0] !== 8'd0 || data_out[1] !== 8'd0) begin
      errors++;
      $display("FAIL reset_flags wr=%b full=%b lo=%b lc=%h d0=%h d1=%h required all 0",
               wr_check, ram_full, last_out, loop_ctrl, data_out[0], data_out[1]);
    end
    rst = 1'b0;
  endtask

  task automatic test_load(input int gap);
    int tw;
    tw = cfg_i * cfg_i * cfg_c;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'd1) begin
      errors++; $display("FAIL load_enter state=%0d required 1", state);
    end
    for (int n = 0; n < tw; n++) begin
      valid_write = 1'b1;
      data_in = ref_mem[n];
      @(negedge clk);
      valid_write = 1'b0;
      checks++;
      if (wr_check !== 1'b1 || counter !== AW'(n + 1) || ram_full !== 1'b0) begin
        errors++;
        $display("FAIL load_beat n=%0d wr=%b counter=%0d full=%b required 1 %0d 0",
                 n, wr_check, counter, ram_full, n + 1);
      end
      if (n < tw - 1) begin
        repeat (gap) begin
          @(negedge clk);
          checks++;
          if (wr_check !== 1'b0 || counter !== AW'(n + 1)) begin
            errors++;
            $display("FAIL load_gap n=%0d wr=%b counter=%0d required 0 %0d", n, wr_check, counter, n + 1);
          end
        end
      end
    end
    valid_write = 1'b1;
    data_in = 16'hFFFF;
    @(negedge clk);
    valid_write = 1'b0;
    checks++;
    if (ram_full !== 1'b1 || state !== 2'd2 || wr_check !== 1'b0 || counter !== '0 || loop_ctrl !== 8'd0) begin
      errors++;
      $display("FAIL load_full full=%b state=%0d wr=%b counter=%0d lc=%h required 1 2 0 0 00",
               ram_full, state, wr_check, counter, loop_ctrl);
    end
  endtask

  task automatic test_stream(input int abort_after);
    int exp_addr[$];
    logic [15:0] exp_data[$];
    logic [7:0] exp_ctrl[$];
    logic [7:0] exp_pix[$];
    int rd_hist[$];
    logic [7:0] pix_hist[$];
    int s, pad, iy, ix, cy, cx, addr, tr, k, first_cyc;
    bit inr, fst, lst;
    s = (cfg_s == 0) ? 1 : cfg_s;
    pad = (cfg_o - 1) * s + cfg_k - cfg_i;
    pad = (pad < 0) ? 0 : pad / 2;
    for (int oy = 0; oy < cfg_o; oy++)
      for (int ox = 0; ox < cfg_o; ox++)
        for (int ky = 0; ky < cfg_k; ky++)
          for (int kx = 0; kx < cfg_k; kx++)
            for (int c = 0; c < cfg_c; c++) begin
              iy = oy * s + ky - pad;
              ix = ox * s + kx - pad;
              inr = (iy >= 0) && (iy < cfg_i) && (ix >= 0) && (ix < cfg_i);
              cy = (iy < 0) ? 0 : (iy >= cfg_i) ? cfg_i - 1 : iy;
              cx = (ix < 0) ? 0 : (ix >= cfg_i) ? cfg_i - 1 : ix;
              addr = (cy * cfg_i + cx) * cfg_c + c;
              fst = (ky == 0) && (kx == 0) && (c == 0);
              lst = (ky == cfg_k - 1) && (kx == cfg_k - 1) && (c == cfg_c - 1);
              exp_addr.push_back(addr);
              exp_data.push_back(inr ? ref_mem[addr] : 16'h0000);
              exp_ctrl.push_back({5'd0, lst, fst, 1'b1});
              exp_pix.push_back(8'(oy * cfg_o + ox));
            end
    tr = exp_addr.size();
    k = 0;
    first_cyc = -1;
    for (int cyc = 0; cyc < tr + 20; cyc++) begin
      @(negedge clk);
      rd_hist.push_back(int'(rd_idx));
      pix_hist.push_back(last);
      if (loop_ctrl[0] === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        checks++;
        if (k >= tr || rd_hist.size() <= LAT) begin
          errors++; $display("FAIL slot_extra k=%0d observed beyond %0d expected slots", k, tr);
        end else begin
          if ({data_out[1], data_out[0]} !== exp_data[k]) begin
            errors++;
            $display("FAIL slot_data k=%0d got=%h required=%h", k, {data_out[1], data_out[0]}, exp_data[k]);
          end
          checks++;
          if (loop_ctrl !== exp_ctrl[k]) begin
            errors++; $display("FAIL slot_ctrl k=%0d got=%h required=%h", k, loop_ctrl, exp_ctrl[k]);
          end
          checks++;
          if (rd_hist[rd_hist.size() - 1 - LAT] !== exp_addr[k]) begin
            errors++;
            $display("FAIL slot_rd_idx k=%0d got=%0d required=%0d", k, rd_hist[rd_hist.size() - 1 - LAT], exp_addr[k]);
          end
          checks++;
          if (pix_hist[pix_hist.size() - 1 - LAT] !== exp_pix[k]) begin
            errors++;
            $display("FAIL slot_pixel k=%0d got=%0d required=%0d", k, pix_hist[pix_hist.size() - 1 - LAT], exp_pix[k]);
          end
          checks++;
          if (cyc - first_cyc != k) begin
            errors++; $display("FAIL slot_gap k=%0d got cycle offset %0d required %0d", k, cyc - first_cyc, k);
          end
        end
        k++;
        if (abort_after > 0 && k == abort_after) begin
          #2 rst = 1'b1;
          #1;
          checks++;
          if (state !== 2'd0 || last_out !== 1'b0 || ram_full !== 1'b0 || loop_ctrl !== 8'd0 || counter !== '0) begin
            errors++;
            $display("FAIL abort state=%0d lo=%b full=%b lc=%h counter=%0d required 0 0 0 00 0",
                     state, last_out, ram_full, loop_ctrl, counter);
          end
          return;
        end
      end
      if (last_out === 1'b1) break;
    end
    checks++;
    if (last_out !== 1'b1 || k != tr) begin
      errors++; $display("FAIL stream_end last_out=%b slots=%0d required 1 %0d", last_out, k, tr);
    end
    checks++;
    if (state !== 2'd3 || loop_ctrl !== 8'd0 || data_out[0] !== 8'd0 || data_out[1] !== 8'd0) begin
      errors++;
      $display("FAIL done_outputs state=%0d lc=%h d0=%h d1=%h required 3 00 00 00",
               state, loop_ctrl, data_out[0], data_out[1]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (last_out !== 1'b1 || state !== 2'd3) begin
      errors++; $display("FAIL done_hold last_out=%b state=%0d required 1 3", last_out, state);
    end
  endtask

  initial begin
    test_reset();
    set_cfg(3, 3, 3, 1, 2);
    fill_mem(1'b0);
    test_load(0);
    test_stream(0);
    do_reset(3);
    test_load(3);
    test_stream(60);
    do_reset(2);
    test_load(0);
    test_stream(0);
    repeat (4) begin
      do_reset(2);
      set_cfg($urandom_range(2, 5), $urandom_range(1, 3), $urandom_range(1, 4),
              $urandom_range(0, 2), $urandom_range(1, 3));
      fill_mem(1'b1);
      test_load($urandom_range(0, 2));
      test_stream(0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
